// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// latency-counter width and the NOP word used as the cleared instruction value.
package imem_responder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int          CNT_W = 3;
  localparam logic [31:0] NOP   = 32'h0000_0000;

endpackage

// File: rtl/imem_responder_dffare.sv
// Enable flop with synchronous active-high reset to a parameterised value;
// the standard output-register cell of this codebase.
module dffare #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: issues one ROM read per accepted PC, waits LATENCY
// cycles, and holds the returned instruction until decode accepts it.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_pc,
  input  logic                  flush,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  stall,
  output logic                  addr_err
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               drop;
  logic [31:0]        pc_p1;

  logic               misaligned;
  logic               req_ok;
  logic               accept;
  logic               capture;
  logic               capture_ok;
  logic               vld_en;

  // Request stage: decide in the request cycle whether the ROM read goes out.
  assign misaligned = (req_pc[1:0] != 2'b00);
  assign req_ok     = req_valid & ~stall & ~flush & ~rst;
  assign accept     = req_ok & ~misaligned;

  assign rom_en     = accept;
  // Upper PC bits are not part of the ROM address, so fetches wrap.
  assign rom_addr   = req_pc[ADDR_WIDTH+1:2];

  assign stall      = ~rst & ((state == WAIT) | (instr_valid & ~instr_ready));

  // Capture stage: rom_data is valid in the cycle the counter reaches one.
  assign capture    = (state == WAIT) && (cnt == CNT_W'(1));
  assign capture_ok = capture & ~drop & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      drop     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= req_ok & misaligned;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
            cnt   <= CNT_W'(LATENCY);
            drop  <= 1'b0;
          end
        end
        WAIT: begin
          if (capture) begin
            state <= IDLE;
            cnt   <= '0;
            drop  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (flush) begin
              drop <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          drop  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_p1 <= req_pc;
    end
  end

  // Output stage: a fresh capture wins; otherwise flush or a handshake clears.
  assign vld_en = capture_ok | flush | instr_ready;

  dffare #(.W(32), .RST_VAL(NOP)) u_instr (
    .clk (clk),
    .rst (rst),
    .en  (capture_ok),
    .d   (rom_data),
    .q   (instr)
  );

  dffare #(.W(32), .RST_VAL(32'h0)) u_instr_pc (
    .clk (clk),
    .rst (rst),
    .en  (capture_ok),
    .d   (pc_p1),
    .q   (instr_pc)
  );

  dffare #(.W(1), .RST_VAL(1'b0)) u_instr_valid (
    .clk (clk),
    .rst (rst),
    .en  (vld_en),
    .d   (capture_ok),
    .q   (instr_valid)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a LATENCY-2 ROM model; ROM word 16
// holds 32'h2408_0005 and every other word a holds 32'h1000_0000 | a.
module tb_imem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic [31:0]           req_pc;
  logic                  flush;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [31:0]           rom_data;
  logic [31:0]           instr;
  logic [31:0]           instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  stall;
  logic                  addr_err;

  int nvec = 0;
  int nmis = 0;

  imem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .flush       (flush),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stall       (stall),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  // ROM model: data appears exactly two cycles after the strobe, junk otherwise.
  logic                  v1 = 1'b0, v2 = 1'b0;
  logic [ADDR_WIDTH-1:0] a1 = '0, a2 = '0;

  always @(posedge clk) begin
    v1 <= rom_en;
    a1 <= rom_addr;
    v2 <= v1;
    a2 <= a1;
  end

  function automatic logic [31:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(16)) return 32'h2408_0005;
    return 32'h1000_0000 | 32'(a);
  endfunction

  assign rom_data = v2 ? rom_word(a2) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b1;
    req_pc      = 32'h0000_0040;
    flush       = 1'b0;
    instr_ready = 1'b1;

    // Reset state, with a request presented that must be ignored.
    tick;
    tick;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_adderr", addr_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rom_en", rom_en, 0);

    // Single fetch of 0x40.
    rst = 1'b0;
    #1;
    chk("f40_rom_en", rom_en, 1);
    chk("f40_addr", rom_addr, 16);
    chk("f40_stall_T", stall, 0);
    tick;
    chk("f40_stall_T1", stall, 1);
    chk("f40_rom_en_T1", rom_en, 0);
    chk("f40_valid_T1", instr_valid, 0);
    tick;
    chk("f40_stall_T2", stall, 1);
    chk("f40_valid_T2", instr_valid, 0);
    tick;
    chk("f40_valid_T3", instr_valid, 1);
    chk("f40_instr", instr, 32'h2408_0005);
    chk("f40_pc", instr_pc, 32'h0000_0040);
    chk("f40_stall_T3", stall, 0);
    chk("f40_reaccept", rom_en, 1);
    req_valid = 1'b0;
    tick;
    chk("f40_valid_T4", instr_valid, 0);
    chk("f40_stall_T4", stall, 0);

    // Back-to-back fetches of 0x0, 0x4, 0x8 spaced LATENCY+1 cycles.
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_pc = 32'(4 * i);
      #1;
      chk("b2b_rom_en", rom_en, 1);
      chk("b2b_addr", rom_addr, 32'(i));
      if (i > 0) begin
        chk("b2b_valid", instr_valid, 1);
        chk("b2b_instr", instr, 32'h1000_0000 + 32'(i - 1));
        chk("b2b_pc", instr_pc, 32'(4 * (i - 1)));
      end
      tick;
      chk("b2b_gap1", rom_en, 0);
      chk("b2b_stall1", stall, 1);
      tick;
      chk("b2b_gap2", rom_en, 0);
      tick;
    end
    req_valid = 1'b0;
    #1;
    chk("b2b_last_valid", instr_valid, 1);
    chk("b2b_last_instr", instr, 32'h1000_0002);
    chk("b2b_last_pc", instr_pc, 32'h0000_0008);
    tick;
    chk("b2b_drain", instr_valid, 0);

    // Backpressure: decode holds off four cycles, next request waits for it.
    instr_ready = 1'b0;
    req_valid   = 1'b1;
    req_pc      = 32'h0000_000C;
    #1;
    chk("bp_rom_en", rom_en, 1);
    tick;
    req_pc = 32'h0000_0010;
    tick;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid", instr_valid, 1);
      chk("bp_hold_instr", instr, 32'h1000_0003);
      chk("bp_hold_pc", instr_pc, 32'h0000_000C);
      chk("bp_hold_stall", stall, 1);
      chk("bp_hold_rom_en", rom_en, 0);
      tick;
    end
    instr_ready = 1'b1;
    #1;
    chk("bp_rel_stall", stall, 0);
    chk("bp_rel_rom_en", rom_en, 1);
    chk("bp_rel_addr", rom_addr, 4);
    tick;
    req_valid = 1'b0;
    chk("bp_rel_clear", instr_valid, 0);
    tick;
    tick;
    chk("bp_next_valid", instr_valid, 1);
    chk("bp_next_instr", instr, 32'h1000_0004);
    chk("bp_next_pc", instr_pc, 32'h0000_0010);
    tick;

    // Flush during WAIT drops the read; flush also blocks a same-cycle request.
    req_valid = 1'b1;
    req_pc    = 32'h0000_0100;
    #1;
    chk("fl_rom_en", rom_en, 1);
    tick;
    req_valid = 1'b0;
    flush     = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_valid_T2", instr_valid, 0);
    tick;
    chk("fl_valid_T3", instr_valid, 0);
    tick;
    chk("fl_valid_T4", instr_valid, 0);
    chk("fl_stall_T4", stall, 0);
    req_valid = 1'b1;
    req_pc    = 32'h0000_0200;
    flush     = 1'b1;
    #1;
    chk("fl_prio_rom_en", rom_en, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_next_rom_en", rom_en, 1);
    chk("fl_next_addr", rom_addr, 128);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("fl_next_valid", instr_valid, 1);
    chk("fl_next_instr", instr, 32'h1000_0080);
    chk("fl_next_pc", instr_pc, 32'h0000_0200);
    tick;

    // Misaligned PC, then a PC that wraps past the ROM size.
    req_valid = 1'b1;
    req_pc    = 32'h0000_0042;
    #1;
    chk("mis_rom_en", rom_en, 0);
    tick;
    req_valid = 1'b0;
    chk("mis_adderr", addr_err, 1);
    chk("mis_state", stall, 0);
    tick;
    chk("mis_adderr_end", addr_err, 0);
    req_valid = 1'b1;
    req_pc    = 32'h0001_0004;
    #1;
    chk("wrap_rom_en", rom_en, 1);
    chk("wrap_addr", rom_addr, 1);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("wrap_valid", instr_valid, 1);
    chk("wrap_instr", instr, 32'h1000_0001);
    chk("wrap_pc", instr_pc, 32'h0001_0004);
    tick;

    // Reset in the middle of a read.
    req_valid = 1'b1;
    req_pc    = 32'h0000_0008;
    #1;
    chk("mr_rom_en", rom_en, 1);
    tick;
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("mr_rom_en_rst", rom_en, 0);
    chk("mr_stall_rst", stall, 0);
    tick;
    chk("mr_valid", instr_valid, 0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_pc", instr_pc, 32'h0);
    chk("mr_adderr", addr_err, 0);
    tick;
    chk("mr_valid_late", instr_valid, 0);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_pc    = 32'h0000_0014;
    #1;
    chk("mr_fresh_rom_en", rom_en, 1);
    chk("mr_fresh_addr", rom_addr, 5);
    tick;
    req_valid = 1'b0;
    tick;
    chk("mr_fresh_early", instr_valid, 0);
    tick;
    chk("mr_fresh_valid", instr_valid, 1);
    chk("mr_fresh_instr", instr, 32'h1000_0005);
    chk("mr_fresh_pc", instr_pc, 32'h0000_0014);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of instruction ROM (1024 words).
REQ-002 SHALL have parameter LATENCY, default 2, ROM read latency in cycles from rom_en to rom_data valid (legal 1..7).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  fetch stage presents a PC this cycle.
REQ-006 req_pc  in  32  byte address of requested instruction.
REQ-007 flush  in  1  redirect (taken branch or jump) from decode; squash in-flight/held instruction.
REQ-008 rom_en  out  1  one-cycle ROM read strobe.
REQ-009 rom_addr  out  ADDR_WIDTH  ROM word address.
REQ-010 rom_data  in  32  ROM read data, valid exactly LATENCY cycles after rom_en.
REQ-011 instr  out  32  fetched instruction to decode.
REQ-012 instr_pc  out  32  byte PC of instr.
REQ-013 instr_valid  out  1  instr/instr_pc valid.
REQ-014 instr_ready  in  1  decode accepts instr this cycle.
REQ-015 stall  out  1  fetch PC-register enable is ~stall.
REQ-016 addr_err  out  1  one-cycle pulse: misaligned request dropped.

Function
REQ-017 FSM states IDLE, WAIT; stall = (state==WAIT) | (instr_valid & ~instr_ready).
REQ-018 Accept: cycle T with req_valid & ~stall & ~flush & req_pc[1:0]==0 -> rom_en=1, rom_addr=req_pc[ADDR_WIDTH+1:2] in T (combinational), pc latched, state->WAIT, latency counter loaded LATENCY.
REQ-019 PC bits above ADDR_WIDTH+1 SHALL be ignored for addressing (wrap), but preserved in instr_pc.
REQ-020 Counter decrements each WAIT cycle; at cycle T+LATENCY rom_data captured into instr, latched pc into instr_pc, instr_valid=1 from T+LATENCY+1, state->IDLE.
REQ-021 instr_valid SHALL hold with instr/instr_pc stable until cycle with instr_ready=1; cleared next cycle unless new capture same edge.
REQ-022 Accept in IDLE SHALL be allowed in the same cycle instr_valid & instr_ready handshake completes (stall low); throughput one instruction per LATENCY+1 cycles.
REQ-023 Misaligned request (req_pc[1:0]!=0, otherwise acceptable): no rom_en, addr_err=1 next cycle, state stays IDLE.
REQ-024 flush has priority over req_valid: same-cycle request not accepted.
REQ-025 flush in WAIT: set drop flag; at capture cycle rom_data discarded, instr_valid stays 0, state->IDLE, drop cleared.
REQ-026 flush while instr_valid=1: instr_valid cleared next cycle regardless of instr_ready.
REQ-027 flush in IDLE with nothing held: no effect.
REQ-028 rom_en SHALL never assert while state==WAIT (at most one read outstanding).

Reset
REQ-029 rst=1 on an edge: state IDLE, counter 0, drop 0, instr_valid 0, instr 0, instr_pc 0, addr_err 0; rom_en 0 and stall 0 while rst held.
REQ-030 rst mid-WAIT SHALL abandon the read; subsequent rom_data ignored.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, NOP constant 32'h0000_0000, counter width constant (3 bits).
REQ-032 Output registers (instr, instr_pc, instr_valid) SHALL use the codebase's enable/reset flop cell dffare; no other sub-module.
REQ-033 ROM itself SHALL be external; block contains no memory array.

Verification
REQ-034 Reset, then req_pc=0x0000_0040 held valid, ROM word 16=0x2408_0005, instr_ready=1 -> rom_en/rom_addr=16 at T, instr_valid at T+3 with instr=0x2408_0005, instr_pc=0x40; stall high T+1..T+2.
REQ-035 Back-to-back pcs 0x0,0x4,0x8, instr_ready=1 -> three instrs in order, accepts spaced 3 cycles, no gaps beyond that.
REQ-036 instr_ready=0 for 4 cycles after instr_valid -> instr held stable, stall high, no rom_en; accept on ready then next request same cycle.
REQ-037 flush at T+1 of request 0x100 -> no instr_valid for it; next request 0x200 fetched normally.
REQ-038 req_pc=0x0000_0042 -> no rom_en, addr_err pulse next cycle; req_pc=0x0001_0004 -> rom_addr=1, instr_pc=0x0001_0004.
REQ-039 rst asserted at T+1 of a read -> instr_valid stays 0, all outputs zero, fresh request post-reset completes in LATENCY+1 cycles.
